// File: rtl/class_hvec_seq.sv
// Sequencer for the class hypervector ROM: walks (class, chunk) addresses,
// captures each ROM chunk into a one-entry output register and streams it out.
module class_hvec_seq #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int N_CLASSES          = 8,
  parameter int N_FRAMES           = 3,
  parameter int ID_W               = 3,
  parameter int IDX_W              = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          cfg_single_i,
  input  logic [ID_W-1:0]               cfg_class_i,
  output logic [ID_W-1:0]               frame_id_o,
  output logic [IDX_W-1:0]              frame_index_o,
  input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DI_PARALLEL_W_BITS-1:0] m_data_o,
  output logic [ID_W-1:0]               m_class_o,
  output logic [IDX_W-1:0]              m_index_o,
  output logic                          m_last_frame_o,
  output logic                          m_last_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ID_W-1:0]  LAST_CLASS = ID_W'(N_CLASSES - 1);
  localparam logic [IDX_W-1:0] LAST_FRAME = IDX_W'(N_FRAMES - 1);

  state_t                          state_q, state_d;
  logic [ID_W-1:0]                 id_q, id_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [ID_W-1:0]                 last_id_q, last_id_d;
  logic                            valid_q, valid_d;
  logic [DI_PARALLEL_W_BITS-1:0]   data_q, data_d;
  logic [ID_W-1:0]                 cls_q, cls_d;
  logic [IDX_W-1:0]                ind_q, ind_d;
  logic                            last_frame_q, last_frame_d;
  logic                            last_q, last_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;

  logic load;
  logic at_final;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    idx_d        = idx_q;
    last_id_d    = last_id_q;
    valid_d      = valid_q;
    data_d       = data_q;
    cls_d        = cls_q;
    ind_d        = ind_q;
    last_frame_d = last_frame_q;
    last_d       = last_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    load         = !valid_q || m_ready_i;
    at_final     = (idx_q == LAST_FRAME) && (id_q == last_id_q);

    if (abort_i) begin
      // Abort wins over everything, including a beat accepted this cycle.
      state_d = IDLE;
      valid_d = 1'b0;
      id_d    = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          id_d  = '0;
          idx_d = '0;
          if (start_i) begin
            if (cfg_single_i && (32'(cfg_class_i) >= N_CLASSES)) begin
              err_d = 1'b1;
            end else begin
              state_d   = RUN;
              id_d      = cfg_single_i ? cfg_class_i : '0;
              last_id_d = cfg_single_i ? cfg_class_i : LAST_CLASS;
            end
          end
        end
        RUN: begin
          if (load) begin
            valid_d      = 1'b1;
            data_d       = class_vec_i;
            cls_d        = id_q;
            ind_d        = idx_q;
            last_frame_d = (idx_q == LAST_FRAME);
            last_d       = at_final;
            if (at_final) begin
              state_d = DRAIN;
            end else if (idx_q == LAST_FRAME) begin
              idx_d = '0;
              id_d  = id_q + ID_W'(1);
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (valid_q && m_ready_i) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
            id_d    = '0;
            idx_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      id_q         <= '0;
      idx_q        <= '0;
      last_id_q    <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      cls_q        <= '0;
      ind_q        <= '0;
      last_frame_q <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      idx_q        <= idx_d;
      last_id_q    <= last_id_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      cls_q        <= cls_d;
      ind_q        <= ind_d;
      last_frame_q <= last_frame_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign frame_id_o     = id_q;
  assign frame_index_o  = idx_q;
  assign m_valid_o      = valid_q;
  assign m_data_o       = data_q;
  assign m_class_o      = cls_q;
  assign m_index_o      = ind_q;
  assign m_last_frame_o = last_frame_q;
  assign m_last_o       = last_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_class_hvec_seq.sv
// Randomized and directed bench for class_hvec_seq against a queue-based
// model of the class/chunk sweep order.
module tb_class_hvec_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, abort_i, cfg_single_i, m_ready_i;
  logic [2:0]  cfg_class_i, frame_id_o, m_class_o;
  logic [1:0]  frame_index_o, m_index_o;
  logic [63:0] class_vec_i, m_data_o;
  logic        m_valid_o, m_last_frame_o, m_last_o, busy_o, done_o, err_o;

  // Second instance built with 6 classes to reach the invalid-class path.
  logic        start6, cfg_single6, ready6, abort6;
  logic [2:0]  cfg_class6, frame_id6, m_class6;
  logic [1:0]  frame_index6, m_index6;
  logic [63:0] class_vec6, m_data6;
  logic        m_valid6, m_last_frame6, m_last6, busy6, done6, err6;

  logic [63:0] rom_tbl [8][4];

  int compared   = 0;
  int mismatched = 0;

  typedef struct { logic [2:0] c; logic [1:0] f; } beat_t;

  always #5 clk = ~clk;

  assign class_vec_i = rom_tbl[frame_id_o][frame_index_o];
  assign class_vec6  = rom_tbl[frame_id6][frame_index6];

  class_hvec_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .cfg_single_i(cfg_single_i), .cfg_class_i(cfg_class_i),
    .frame_id_o(frame_id_o), .frame_index_o(frame_index_o),
    .class_vec_i(class_vec_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_class_o(m_class_o), .m_index_o(m_index_o),
    .m_last_frame_o(m_last_frame_o), .m_last_o(m_last_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  class_hvec_seq #(.N_CLASSES(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start_i(start6), .abort_i(abort6),
    .cfg_single_i(cfg_single6), .cfg_class_i(cfg_class6),
    .frame_id_o(frame_id6), .frame_index_o(frame_index6),
    .class_vec_i(class_vec6), .m_valid_o(m_valid6), .m_ready_i(ready6),
    .m_data_o(m_data6), .m_class_o(m_class6), .m_index_o(m_index6),
    .m_last_frame_o(m_last_frame6), .m_last_o(m_last6),
    .busy_o(busy6), .done_o(done6), .err_o(err6)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high (exact timing checked), 1: ready 1,0,0,1, 2: random ready
  task automatic sweep(input bit single, input logic [2:0] cls, input int mode);
    beat_t       exp_q[$];
    beat_t       hd;
    int          total, n, last_acc;
    bit          finished, held;
    logic [63:0] h_data;
    logic [2:0]  h_cls;
    logic [1:0]  h_idx;
    n = 0; last_acc = -10; finished = 0; held = 0;
    for (int c = 0; c < 8; c++)
      if (!single || c == int'(cls))
        for (int f = 0; f < 3; f++) exp_q.push_back('{c: 3'(c), f: 2'(f)});
    total = exp_q.size();
    start_i = 1'b1; cfg_single_i = single; cfg_class_i = cls; m_ready_i = 1'b1;
    for (int cyc = 1; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start_i = 1'b0;
      if (cyc == 3) begin cfg_class_i = 3'd2; cfg_single_i = !single; end
      if (mode == 2 && !single && cyc == 6) start_i = 1'b1;
      if (mode == 2 && !single && cyc == 7) start_i = 1'b0;
      chk("err_quiet", err_o, 1'b0);
      if (done_o) begin
        finished = 1;
        chk("done_after_last_accept", cyc, last_acc + 1);
        chk("beats_remaining", exp_q.size(), 0);
        chk("busy_at_done", busy_o, 1'b0);
        chk("valid_at_done", m_valid_o, 1'b0);
        chk("addr_idle", {frame_id_o, frame_index_o}, 5'd0);
        if (mode == 0) chk("done_cycle", cyc, total + 2);
      end else begin
        chk("busy", busy_o, 1'b1);
        if (mode == 0) chk("valid_stream", m_valid_o, cyc >= 2);
        if (held) begin
          chk("stall_valid", m_valid_o, 1'b1);
          chk("stall_data", m_data_o, h_data);
          chk("stall_class", m_class_o, h_cls);
          chk("stall_index", m_index_o, h_idx);
        end
        case (mode)
          0: m_ready_i = 1'b1;
          1: m_ready_i = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
          default: m_ready_i = 1'($urandom_range(0, 1));
        endcase
        chk("unexpected_beat", m_valid_o && exp_q.size() == 0, 1'b0);
        if (m_valid_o && exp_q.size() > 0) begin
          hd = exp_q[0];
          if (!held) begin
            if (mode == 0) chk("beat_cycle", cyc, n + 2);
            chk("beat_class", m_class_o, hd.c);
            chk("beat_index", m_index_o, hd.f);
            chk("beat_data", m_data_o, rom_tbl[hd.c][hd.f]);
            chk("beat_last_frame", m_last_frame_o, hd.f == 2'd2);
            chk("beat_last", m_last_o, exp_q.size() == 1);
          end
          if (m_ready_i) begin
            void'(exp_q.pop_front());
            n++;
            last_acc = cyc;
            held = 0;
          end else begin
            held = 1; h_data = m_data_o; h_cls = m_class_o; h_idx = m_index_o;
          end
        end
      end
    end
    chk("sweep_finished", finished, 1'b1);
    $display("sweep single=%0d class=%0d mode=%0d: %0d of %0d beats accepted", single, cls, mode, n, total);
  endtask

  initial begin
    bit found;
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 4; f++) rom_tbl[c][f] = {$urandom, $urandom};
    rst_n = 1'b0; start_i = 0; abort_i = 0; cfg_single_i = 0; cfg_class_i = 0; m_ready_i = 0;
    start6 = 0; abort6 = 0; cfg_single6 = 0; cfg_class6 = 0; ready6 = 1;

    @(negedge clk);
    chk("rst_valid", m_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_data", m_data_o, 64'd0);
    chk("rst_addr", {frame_id_o, frame_index_o}, 5'd0);
    chk("rst_flags", {done_o, err_o, m_last_o, m_last_frame_o}, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    sweep(0, 3'd0, 0);
    sweep(0, 3'd0, 1);
    sweep(1, 3'd5, 0);
    sweep(1, 3'd3, 2);
    sweep(0, 3'd0, 2);

    // Invalid class on the 6-class build, then a valid class on the same build.
    start6 = 1; cfg_single6 = 1; cfg_class6 = 3'd7;
    @(negedge clk);
    start6 = 0;
    chk("inv_err_pulse", err6, 1'b1);
    chk("inv_busy", busy6, 1'b0);
    @(negedge clk);
    chk("inv_err_clear", err6, 1'b0);
    chk("inv_no_beat", {m_valid6, busy6}, 2'b00);
    start6 = 1; cfg_class6 = 3'd5;
    @(negedge clk);
    start6 = 0;
    chk("valid6_no_err", err6, 1'b0);
    chk("valid6_busy", busy6, 1'b1);
    abort6 = 1;
    @(negedge clk);
    abort6 = 0;
    $display("invalid-config checks done");

    // Abort while beat (3,1) is presented and ready is high.
    start_i = 1; cfg_single_i = 0; cfg_class_i = 0; m_ready_i = 1; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      start_i = 0;
      if (m_valid_o && m_class_o == 3'd3 && m_index_o == 2'd1) found = 1;
    end
    chk("abort_beat_found", found, 1'b1);
    abort_i = 1;
    @(negedge clk);
    abort_i = 0;
    chk("abort_valid", m_valid_o, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_no_done", done_o, 1'b0);
    chk("abort_addr", {frame_id_o, frame_index_o}, 5'd0);
    @(negedge clk);
    chk("abort_no_done_late", done_o, 1'b0);
    $display("abort at (3,1) done");
    sweep(0, 3'd0, 0);

    // Asynchronous reset between clock edges in the middle of a sweep.
    start_i = 1; cfg_single_i = 0; m_ready_i = 1;
    @(negedge clk);
    start_i = 0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0; start_i = 1;
    #1;
    chk("arst_valid", m_valid_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_data", m_data_o, 64'd0);
    chk("arst_tags", {m_class_o, m_index_o, frame_id_o, frame_index_o}, 10'd0);
    @(negedge clk);
    chk("arst_start_ignored", {busy_o, m_valid_o}, 2'b00);
    start_i = 0; rst_n = 1'b1;
    @(negedge clk);
    $display("async reset mid-sweep done");
    sweep(1, 3'd7, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
